// File: rtl/vip_src_arbiter.sv
// Frame-boundary arbiter sharing one RGB565 converter between two sources.
// Define VIP_ARB_DROP_CNT_EN to add per-source dropped-frame counters.
module vip_src_arbiter #(
    parameter int FRAMES_PER_GRANT = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src0_req,
    input  logic             src0_vsync,
    input  logic             src0_hsync,
    input  logic             src0_de,
    input  logic [4:0]       src0_red,
    input  logic [5:0]       src0_green,
    input  logic [4:0]       src0_blue,
    input  logic             src1_req,
    input  logic             src1_vsync,
    input  logic             src1_hsync,
    input  logic             src1_de,
    input  logic [4:0]       src1_red,
    input  logic [5:0]       src1_green,
    input  logic [4:0]       src1_blue,
    output logic             out_vsync,
    output logic             out_hsync,
    output logic             out_de,
    output logic [4:0]       out_red,
    output logic [5:0]       out_green,
    output logic [4:0]       out_blue,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt0,
    output logic [CNT_W-1:0] frame_cnt1
`ifdef VIP_ARB_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0] drop_cnt0,
    output logic [CNT_W-1:0] drop_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        ACTIVE
    } state_t;

    localparam int FPG = (FRAMES_PER_GRANT < 1) ? 1 : FRAMES_PER_GRANT;
    localparam logic [CNT_W:0] FPG_V = (CNT_W+1)'(FPG);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             cand_q, cand_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] frames_done_q, frames_done_d;
    logic [1:0]       vsync_q;

    logic [1:0]       req;
    logic [1:0]       vs;
    logic [1:0]       rise;
    logic             sel;
    logic             other;
    logic [CNT_W:0]   fd_inc;
    logic             yield;
    logic             pass;
    logic [1:0]       fwd_rise;

    logic             mux_vsync, mux_hsync, mux_de;
    logic [4:0]       mux_red, mux_blue;
    logic [5:0]       mux_green;

    assign req    = {src1_req, src0_req};
    assign vs     = {src1_vsync, src0_vsync};
    assign rise   = vs & ~vsync_q;
    assign busy   = (state_q != IDLE);
    assign sel    = (state_q == ACTIVE) ? owner_q : cand_q;
    assign other  = ~owner_q;
    assign fd_inc = {1'b0, frames_done_q} + (CNT_W+1)'(1);

    // A grant ends only on the owner's frame boundary.
    assign yield = (state_q == ACTIVE) && rise[owner_q] &&
                   (!req[owner_q] || ((fd_inc >= FPG_V) && req[other]));

    assign pass = ((state_q == ACTIVE) && !yield) ||
                  ((state_q == WAIT_SOF) && rise[cand_q] && req[cand_q]);

    assign fwd_rise[0] = pass && !sel && rise[0];
    assign fwd_rise[1] = pass && sel && rise[1];

    assign mux_vsync = sel ? src1_vsync : src0_vsync;
    assign mux_hsync = sel ? src1_hsync : src0_hsync;
    assign mux_de    = sel ? src1_de    : src0_de;
    assign mux_red   = sel ? src1_red   : src0_red;
    assign mux_green = sel ? src1_green : src0_green;
    assign mux_blue  = sel ? src1_blue  : src0_blue;

    always_comb begin
        state_d       = state_q;
        cand_d        = cand_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        frames_done_d = frames_done_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = WAIT_SOF;
                    cand_d  = (&req) ? ~ptr_q : req[1];
                end
            end
            WAIT_SOF: begin
                if (!req[cand_q]) begin
                    state_d = IDLE;
                end else if (rise[cand_q]) begin
                    state_d       = ACTIVE;
                    owner_d       = cand_q;
                    frames_done_d = '0;
                end
            end
            ACTIVE: begin
                if (rise[owner_q]) begin
                    if (yield) begin
                        ptr_d = owner_q;
                        if (req[other]) begin
                            state_d = WAIT_SOF;
                            cand_d  = other;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (!(&frames_done_q)) begin
                        frames_done_d = frames_done_q + ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cand_q        <= 1'b0;
            owner_q       <= 1'b0;
            ptr_q         <= 1'b1;
            frames_done_q <= '0;
            vsync_q       <= 2'b00;
            out_vsync     <= 1'b0;
            out_hsync     <= 1'b0;
            out_de        <= 1'b0;
            out_red       <= '0;
            out_green     <= '0;
            out_blue      <= '0;
            grant         <= 2'b00;
            frame_cnt0    <= '0;
            frame_cnt1    <= '0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            frames_done_q <= frames_done_d;
            vsync_q       <= vs;
            out_vsync     <= pass && mux_vsync;
            out_hsync     <= pass && mux_hsync;
            out_de        <= pass && mux_de;
            out_red       <= pass ? mux_red   : '0;
            out_green     <= pass ? mux_green : '0;
            out_blue      <= pass ? mux_blue  : '0;
            grant         <= pass ? (sel ? 2'b10 : 2'b01) : 2'b00;
            if (fwd_rise[0] && !(&frame_cnt0))
                frame_cnt0 <= frame_cnt0 + ONE;
            if (fwd_rise[1] && !(&frame_cnt1))
                frame_cnt1 <= frame_cnt1 + ONE;
        end
    end

`ifdef VIP_ARB_DROP_CNT_EN
    logic [1:0] drop;

    assign drop = rise & req & ~fwd_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt0 <= '0;
            drop_cnt1 <= '0;
        end else begin
            if (drop[0] && !(&drop_cnt0))
                drop_cnt0 <= drop_cnt0 + ONE;
            if (drop[1] && !(&drop_cnt1))
                drop_cnt1 <= drop_cnt1 + ONE;
        end
    end
`endif

endmodule

// File: tb/tb_vip_src_arbiter.sv
// Directed bench for vip_src_arbiter (FRAMES_PER_GRANT=2).
module tb_vip_src_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        src0_req, src0_vsync, src0_hsync, src0_de;
    logic [4:0]  src0_red, src0_blue;
    logic [5:0]  src0_green;
    logic        src1_req, src1_vsync, src1_hsync, src1_de;
    logic [4:0]  src1_red, src1_blue;
    logic [5:0]  src1_green;
    logic        out_vsync, out_hsync, out_de;
    logic [4:0]  out_red, out_blue;
    logic [5:0]  out_green;
    logic [1:0]  grant;
    logic        busy;
    logic [15:0] frame_cnt0, frame_cnt1;
`ifdef VIP_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt0, drop_cnt1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vip_src_arbiter #(
        .FRAMES_PER_GRANT(2),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .src0_req(src0_req),
        .src0_vsync(src0_vsync),
        .src0_hsync(src0_hsync),
        .src0_de(src0_de),
        .src0_red(src0_red),
        .src0_green(src0_green),
        .src0_blue(src0_blue),
        .src1_req(src1_req),
        .src1_vsync(src1_vsync),
        .src1_hsync(src1_hsync),
        .src1_de(src1_de),
        .src1_red(src1_red),
        .src1_green(src1_green),
        .src1_blue(src1_blue),
        .out_vsync(out_vsync),
        .out_hsync(out_hsync),
        .out_de(out_de),
        .out_red(out_red),
        .out_green(out_green),
        .out_blue(out_blue),
        .grant(grant),
        .busy(busy),
        .frame_cnt0(frame_cnt0),
        .frame_cnt1(frame_cnt1)
`ifdef VIP_ARB_DROP_CNT_EN
        ,
        .drop_cnt0(drop_cnt0),
        .drop_cnt1(drop_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle; eg names the source expected on the outputs.
    task automatic cyc(input logic v0, input logic h0, input logic d0,
                       input logic [15:0] p0,
                       input logic v1, input logic h1, input logic d1,
                       input logic [15:0] p1,
                       input logic [1:0] eg);
        logic [18:0] e;
        src0_vsync = v0;
        src0_hsync = h0;
        src0_de    = d0;
        src0_red   = p0[15:11];
        src0_green = p0[10:5];
        src0_blue  = p0[4:0];
        src1_vsync = v1;
        src1_hsync = h1;
        src1_de    = d1;
        src1_red   = p1[15:11];
        src1_green = p1[10:5];
        src1_blue  = p1[4:0];
        @(posedge clk);
        #1;
        if (eg == 2'b01)
            e = {v0, h0, d0, p0};
        else if (eg == 2'b10)
            e = {v1, h1, d1, p1};
        else
            e = '0;
        chk("grant", {30'd0, grant}, {30'd0, eg});
        chk("out", {13'd0, out_vsync, out_hsync, out_de,
                    out_red, out_green, out_blue}, {13'd0, e});
    endtask

    task automatic sdrive(input bit s, input logic v, input logic h,
                          input logic d, input logic [15:0] p,
                          input logic [1:0] eg);
        if (s)
            cyc(1'b0, 1'b0, 1'b0, 16'h0, v, h, d, p, eg);
        else
            cyc(v, h, d, p, 1'b0, 1'b0, 1'b0, 16'h0, eg);
    endtask

    task automatic idle(input logic [1:0] eg);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, eg);
    endtask

    // 2 vsync cycles, 4 lines of 8 pixels, 1 blank cycle.
    task automatic frame(input bit s, input logic [15:0] base,
                         input logic [1:0] er, input logic [1:0] eb);
        logic [15:0] p;
        sdrive(s, 1'b1, 1'b0, 1'b0, ~base, er);
        sdrive(s, 1'b1, 1'b0, 1'b0, base ^ 16'h5a5a, eb);
        for (int l = 0; l < 4; l++) begin
            sdrive(s, 1'b0, 1'b1, 1'b0, 16'h0, eb);
            for (int x = 0; x < 8; x++) begin
                p = base + 16'(l * 8 + x);
                sdrive(s, 1'b0, 1'b0, 1'b1, p, eb);
            end
        end
        sdrive(s, 1'b0, 1'b0, 1'b0, 16'h0, eb);
    endtask

    initial begin
        rst      = 1'b1;
        src0_req = 1'b0;
        src1_req = 1'b0;
        idle(2'b00);
        idle(2'b00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fc0", {16'd0, frame_cnt0}, 32'd0);
        chk("rst_fc1", {16'd0, frame_cnt1}, 32'd0);
`ifdef VIP_ARB_DROP_CNT_EN
        chk("rst_dc0", {16'd0, drop_cnt0}, 32'd0);
        chk("rst_dc1", {16'd0, drop_cnt1}, 32'd0);
`endif
        rst = 1'b0;

        // Single requester
        src0_req = 1'b1;
        idle(2'b00);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        frame(1'b0, 16'h1234, 2'b01, 2'b01);
        chk("t1_fc0a", {16'd0, frame_cnt0}, 32'd1);
        frame(1'b0, 16'hf800, 2'b01, 2'b01);
        chk("t1_fc0b", {16'd0, frame_cnt0}, 32'd2);
        frame(1'b0, 16'h07e0, 2'b01, 2'b01);
        chk("t1_fc0c", {16'd0, frame_cnt0}, 32'd3);

        // Both requesting, alternating two frames per grant
        rst = 1'b1;
        idle(2'b00);
        rst = 1'b0;
        src1_req = 1'b1;
        idle(2'b00);
        frame(1'b0, 16'h0101, 2'b01, 2'b01);
        frame(1'b1, 16'h1f00, 2'b01, 2'b01);
        frame(1'b0, 16'h0202, 2'b01, 2'b01);
        chk("t2_fc0a", {16'd0, frame_cnt0}, 32'd2);
        frame(1'b1, 16'h2e00, 2'b01, 2'b01);
        frame(1'b0, 16'h0303, 2'b00, 2'b00);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        frame(1'b1, 16'h3d00, 2'b10, 2'b10);
        chk("t2_fc1a", {16'd0, frame_cnt1}, 32'd1);
        frame(1'b0, 16'h0404, 2'b10, 2'b10);
        frame(1'b1, 16'h4c00, 2'b10, 2'b10);
        frame(1'b0, 16'h0505, 2'b10, 2'b10);
        frame(1'b1, 16'h5b00, 2'b00, 2'b00);
        frame(1'b0, 16'h0606, 2'b01, 2'b01);
        chk("t2_fc0b", {16'd0, frame_cnt0}, 32'd3);
        chk("t2_fc1b", {16'd0, frame_cnt1}, 32'd2);
`ifdef VIP_ARB_DROP_CNT_EN
        chk("t2_dc0", {16'd0, drop_cnt0}, 32'd3);
        chk("t2_dc1", {16'd0, drop_cnt1}, 32'd3);
`endif

        // Owner drops request inside its frame
        src1_req = 1'b0;
        frame(1'b0, 16'h0707, 2'b01, 2'b01);
        chk("t3_fc0a", {16'd0, frame_cnt0}, 32'd4);
        src0_req = 1'b0;
        idle(2'b01);
        idle(2'b01);
        chk("t3_busy1", {31'd0, busy}, 32'd1);
        frame(1'b0, 16'h0808, 2'b00, 2'b00);
        chk("t3_busy0", {31'd0, busy}, 32'd0);
        chk("t3_fc0b", {16'd0, frame_cnt0}, 32'd4);

        // Candidate drops request before its frame starts
        src1_req = 1'b1;
        idle(2'b00);
        chk("t4_busy1", {31'd0, busy}, 32'd1);
        src1_req = 1'b0;
        idle(2'b00);
        chk("t4_busy0", {31'd0, busy}, 32'd0);
        frame(1'b1, 16'h9999, 2'b00, 2'b00);
        chk("t4_fc1", {16'd0, frame_cnt1}, 32'd2);

        // Reset in the middle of an active line
        src0_req = 1'b1;
        idle(2'b00);
        sdrive(1'b0, 1'b1, 1'b0, 1'b0, 16'habcd, 2'b01);
        chk("t5_fc0", {16'd0, frame_cnt0}, 32'd5);
        sdrive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 2'b01);
        sdrive(1'b0, 1'b0, 1'b0, 1'b1, 16'hc0de, 2'b01);
        sdrive(1'b0, 1'b0, 1'b0, 1'b1, 16'hbeef, 2'b01);
        rst = 1'b1;
        sdrive(1'b0, 1'b0, 1'b0, 1'b1, 16'hface, 2'b00);
        chk("t5_rfc0", {16'd0, frame_cnt0}, 32'd0);
        chk("t5_rfc1", {16'd0, frame_cnt1}, 32'd0);
        chk("t5_rbusy", {31'd0, busy}, 32'd0);
        rst      = 1'b0;
        src0_req = 1'b0;
        src1_req = 1'b1;
        idle(2'b00);
        frame(1'b1, 16'h7777, 2'b10, 2'b10);
        chk("t5_fc1", {16'd0, frame_cnt1}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
